counter_modn: RTL and testbench

Parametrised modulo-N up/down counter, the next generation of the team's fixed 20-state counter. It adds configurable width and modulus, synchronous clear, parallel load with range checking, and three run modes: wrap, saturate and one-shot. It also provides a combinational terminal-count output for cascading, plus registered wrap/done/error flags. It sits in the timing/sequencing datapath wherever a programmable event counter or divider is needed.

---
 rtl/counter_modn.sv | 120 ++++++++++++
 tb/tb_counter_modn.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_modn.sv
// Parametrised modulo-N up/down counter with wrap, saturate and one-shot modes,
// synchronous clear, range-checked parallel load and a combinational cascade tc.
module counter_modn #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 20
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             start,
  input  logic             ud,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] state,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("counter_modn: MODULUS must lie in 2 .. 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_state_nxt;
  logic [WIDTH-1:0] w_term;
  logic             w_at_term;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_err;
  logic             w_err_nxt;

  // Terminal value follows the live direction, so a ud flip at terminal is seen at once.
  assign w_term    = ud ? {WIDTH{1'b0}} : LAST;
  assign w_at_term = (r_state == w_term);

  assign tc    = start & w_at_term;
  assign state = r_state;
  assign wrap  = r_wrap;
  assign done  = (r_fsm == ST_DONE);
  assign err   = r_err;

  // State, flag and one-shot FSM registers.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state <= {WIDTH{1'b0}};
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_fsm   <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
      r_fsm   <= w_fsm_nxt;
    end
  end

  // Next-state decode: clr > load > DONE hold/exit > count > hold.
  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_fsm_nxt   = r_fsm;
    if (clr) begin
      w_state_nxt = {WIDTH{1'b0}};
      w_err_nxt   = 1'b0;
      w_fsm_nxt   = ST_RUN;
    end else if (load) begin
      w_fsm_nxt = ST_RUN;
      if ({1'b0, din} < MOD_EXT) begin
        w_state_nxt = din;
      end else begin
        w_state_nxt = LAST;
        w_err_nxt   = 1'b1;
      end
    end else if (r_fsm == ST_DONE) begin
      // Leaving DONE on a mode change does not count on that same cycle.
      if (mode != 2'b10) begin
        w_fsm_nxt = ST_RUN;
      end else begin
        w_fsm_nxt = ST_DONE;
      end
    end else if (start) begin
      if (w_at_term) begin
        case (mode)
          2'b01: begin
            w_state_nxt = r_state;
          end
          2'b10: begin
            w_fsm_nxt = ST_DONE;
          end
          default: begin
            w_state_nxt = ud ? LAST : {WIDTH{1'b0}};
            w_wrap_nxt  = 1'b1;
          end
        endcase
      end else if (ud) begin
        w_state_nxt = r_state - ONE;
      end else begin
        w_state_nxt = r_state + ONE;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

endmodule

// File: tb/tb_counter_modn.sv
// Scoreboard bench: three counter instances (20/5b, 16/4b, 100/8b) share random stimulus
// and are checked against an integer-arithmetic reference model.
module tb_counter_modn;

  logic       mclk = 1'b0;
  logic       reset, start, ud, clr, load;
  logic [7:0] din;
  logic [1:0] mode;
  logic [4:0] st0;
  logic [3:0] st1;
  logic [7:0] st2;
  logic [2:0] tc_a, wr_a, dn_a, er_a;

  counter_modn #(.WIDTH(5), .MODULUS(20)) u_m20 (
    .mclk(mclk), .reset(reset), .start(start), .ud(ud), .clr(clr), .load(load),
    .din(din[4:0]), .mode(mode), .state(st0), .tc(tc_a[0]), .wrap(wr_a[0]),
    .done(dn_a[0]), .err(er_a[0]));
  counter_modn #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .mclk(mclk), .reset(reset), .start(start), .ud(ud), .clr(clr), .load(load),
    .din(din[3:0]), .mode(mode), .state(st1), .tc(tc_a[1]), .wrap(wr_a[1]),
    .done(dn_a[1]), .err(er_a[1]));
  counter_modn #(.WIDTH(8), .MODULUS(100)) u_m100 (
    .mclk(mclk), .reset(reset), .start(start), .ud(ud), .clr(clr), .load(load),
    .din(din), .mode(mode), .state(st2), .tc(tc_a[2]), .wrap(wr_a[2]),
    .done(dn_a[2]), .err(er_a[2]));

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [2:0][7:0] st;
    logic [2:0]      wr;
    logic [2:0]      dn;
    logic [2:0]      er;
  } exp_t;

  int   mods[3]  = '{20, 16, 100};
  int   masks[3] = '{31, 15, 255};
  exp_t reg_q[$];
  logic [2:0] tc_q[$];
  int   m_st[3];
  bit   m_wr[3], m_dn[3], m_er[3];
  int   checks = 0;
  int   failures = 0;

  function automatic int act_state(int i);
    if (i == 0) return int'(st0);
    else if (i == 1) return int'(st1);
    else return int'(st2);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d expected=%0d at t=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Reference model: each instance is a number in [0, M) stepped by plain arithmetic.
  task automatic model_step(input bit s, input bit u, input bit c, input bit l,
                            input int d, input int md);
    for (int i = 0; i < 3; i++) begin
      int m, dv, term;
      m    = mods[i];
      dv   = d & masks[i];
      term = u ? 0 : m - 1;
      m_wr[i] = 1'b0;
      if (c) begin
        m_st[i] = 0; m_dn[i] = 1'b0; m_er[i] = 1'b0;
      end else if (l) begin
        m_dn[i] = 1'b0;
        if (dv < m) m_st[i] = dv;
        else begin m_st[i] = m - 1; m_er[i] = 1'b1; end
      end else if (m_dn[i]) begin
        if (md != 2) m_dn[i] = 1'b0;
      end else if (s) begin
        if (md == 1) begin
          if (u) m_st[i] = (m_st[i] > 0) ? m_st[i] - 1 : 0;
          else   m_st[i] = (m_st[i] < m - 1) ? m_st[i] + 1 : m - 1;
        end else if (md == 2 && m_st[i] == term) begin
          m_dn[i] = 1'b1;
        end else begin
          m_wr[i] = (m_st[i] == term);
          m_st[i] = (m_st[i] + (u ? m - 1 : 1)) % m;
        end
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, queue expected tc now and registers after the edge.
  task automatic cyc(input bit s, input bit u, input bit c, input bit l, input int d, input int md);
    logic [2:0] t;
    exp_t e;
    @(negedge mclk);
    start = s; ud = u; clr = c; load = l; din = 8'(d); mode = 2'(md);
    for (int i = 0; i < 3; i++) t[i] = s && (m_st[i] == (u ? 0 : mods[i] - 1));
    tc_q.push_back(t);
    model_step(s, u, c, l, d, md);
    for (int i = 0; i < 3; i++) begin
      e.st[i] = 8'(m_st[i]); e.wr[i] = m_wr[i]; e.dn[i] = m_dn[i]; e.er[i] = m_er[i];
    end
    reg_q.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next rising edge.
  task automatic do_reset();
    @(negedge mclk);
    start = 1'b0; ud = 1'b0; clr = 1'b0; load = 1'b0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_state", i, act_state(i), 0);
      chk("rst_wrap", i, int'(wr_a[i]), 0);
      chk("rst_done", i, int'(dn_a[i]), 0);
      chk("rst_err", i, int'(er_a[i]), 0);
      chk("rst_tc", i, int'(tc_a[i]), 0);
      m_st[i] = 0; m_wr[i] = 1'b0; m_dn[i] = 1'b0; m_er[i] = 1'b0;
    end
    @(negedge mclk);
    reset = 1'b1;
  endtask

  // Monitor: registered outputs, one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge mclk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk("state", i, act_state(i), int'(e.st[i]));
          chk("wrap", i, int'(wr_a[i]), int'(e.wr[i]));
          chk("done", i, int'(dn_a[i]), int'(e.dn[i]));
          chk("err", i, int'(er_a[i]), int'(e.er[i]));
        end
      end
    end
  end

  // Monitor: combinational tc, checked mid-cycle after the stimulus settles.
  initial begin
    logic [2:0] t;
    forever begin
      @(negedge mclk);
      #1;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        for (int i = 0; i < 3; i++) chk("tc", i, int'(tc_a[i]), int'(t[i]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ru;
    int rm;
    reset = 1'b0; start = 1'b0; ud = 1'b0; clr = 1'b0; load = 1'b0; din = 8'd0; mode = 2'd0;
    do_reset();
    for (int k = 0; k < 25; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset();
    for (int k = 0; k < 25; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17, 1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 15, 2);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3, 2);
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 18, 2);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 25, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 255, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 7, 0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 102; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ru = 1'b0;
    rm = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) ru = ~ru;
      if ($urandom_range(0, 15) == 0) rm = int'($urandom_range(0, 3));
      if (k % 500 == 499) do_reset();
      cyc($urandom_range(0, 7) != 0, ru, $urandom_range(0, 40) == 0,
          $urandom_range(0, 20) == 0, int'($urandom_range(0, 255)), rm);
    end
    @(posedge mclk);
    #3;
    chk("queue_drained", 0, reg_q.size() + tc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
